// File: rtl/bus_controller_if.sv
// bus_controller_if: two-core snooping bus plus L2 port, as seen by the bus controller.
interface bus_controller_if;
    logic        req_core_0, req_core_1;
    logic [1:0]  bus_operation_out_0, bus_operation_out_1;
    logic [31:0] bus_address_out_0, bus_address_out_1;
    logic        cache_hit_out_0, cache_hit_out_1;
    logic        flush_out_0, flush_out_1;
    logic [31:0] bus_data_out_0, bus_data_out_1;
    logic [31:0] data_to_L2_0, data_to_L2_1;
    logic [24:0] tag_to_L2_0, tag_to_L2_1;
    logic        grant_0, grant_1;
    logic [1:0]  bus_operation_in_0, bus_operation_in_1;
    logic [31:0] bus_address_in_0, bus_address_in_1;
    logic [31:0] bus_data_in_0, bus_data_in_1;
    logic [1:0]  cache_hit_in_0, cache_hit_in_1;
    logic        l2_req, l2_we;
    logic [31:0] l2_addr, l2_wdata, l2_rdata;
    logic        l2_ready;
    logic        bus_error;

    modport master (
        input  req_core_0, req_core_1, bus_operation_out_0, bus_operation_out_1,
               bus_address_out_0, bus_address_out_1, cache_hit_out_0, cache_hit_out_1,
               flush_out_0, flush_out_1, bus_data_out_0, bus_data_out_1,
               data_to_L2_0, data_to_L2_1, tag_to_L2_0, tag_to_L2_1, l2_rdata, l2_ready,
        output grant_0, grant_1, bus_operation_in_0, bus_operation_in_1,
               bus_address_in_0, bus_address_in_1, bus_data_in_0, bus_data_in_1,
               cache_hit_in_0, cache_hit_in_1, l2_req, l2_we, l2_addr, l2_wdata, bus_error
    );

    modport slave (
        output req_core_0, req_core_1, bus_operation_out_0, bus_operation_out_1,
               bus_address_out_0, bus_address_out_1, cache_hit_out_0, cache_hit_out_1,
               flush_out_0, flush_out_1, bus_data_out_0, bus_data_out_1,
               data_to_L2_0, data_to_L2_1, tag_to_L2_0, tag_to_L2_1, l2_rdata, l2_ready,
        input  grant_0, grant_1, bus_operation_in_0, bus_operation_in_1,
               bus_address_in_0, bus_address_in_1, bus_data_in_0, bus_data_in_1,
               cache_hit_in_0, cache_hit_in_1, l2_req, l2_we, l2_addr, l2_wdata, bus_error
    );
endinterface

// File: rtl/bus_controller.sv
// bus_controller: round-robin two-core snooping bus arbiter with L2 fill, write-back and fetch timeout.
module bus_controller #(
    parameter int L2_TIMEOUT = 64
) (
    input logic clk,
    input logic reset,
    bus_controller_if.master bus
);
    localparam int CW = $clog2(L2_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(L2_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, GRANT, SNOOP, FETCH, DONE} state_t;

    state_t      state;
    logic        owner, rr, err;
    logic [1:0]  op, code;
    logic [31:0] addr, data;
    logic [CW-1:0] cnt;

    // owner-side request fields and non-owner (snooper) responses
    logic [1:0]  own_op;
    logic [31:0] own_addr, snp_data, snp_wdata;
    logic [24:0] snp_tag;
    logic        snp_hit, snp_flush, flush_now, unused_tag;

    assign own_op     = owner ? bus.bus_operation_out_1 : bus.bus_operation_out_0;
    assign own_addr   = owner ? bus.bus_address_out_1 : bus.bus_address_out_0;
    assign snp_hit    = owner ? bus.cache_hit_out_0 : bus.cache_hit_out_1;
    assign snp_data   = owner ? bus.bus_data_out_0 : bus.bus_data_out_1;
    assign snp_flush  = owner ? bus.flush_out_0 : bus.flush_out_1;
    assign snp_wdata  = owner ? bus.data_to_L2_0 : bus.data_to_L2_1;
    assign snp_tag    = owner ? bus.tag_to_L2_0 : bus.tag_to_L2_1;
    assign flush_now  = state == SNOOP && snp_flush;
    assign unused_tag = ^{bus.tag_to_L2_0[24], bus.tag_to_L2_1[24]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            rr    <= 1'b0;
            err   <= 1'b0;
            op    <= 2'b11;
            code  <= 2'b00;
            addr  <= '0;
            data  <= '0;
            cnt   <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: if (bus.req_core_0 || bus.req_core_1) begin
                    owner <= (bus.req_core_0 && bus.req_core_1) ? rr : bus.req_core_1;
                    state <= GRANT;
                end
                GRANT: begin
                    op    <= own_op;
                    addr  <= own_addr;
                    data  <= '0;
                    code  <= 2'b00;
                    cnt   <= '0;
                    state <= own_op == 2'b11 ? DONE : SNOOP;
                end
                SNOOP: begin
                    if (op != 2'b01 && snp_hit) begin
                        data <= snp_data;
                        code <= op == 2'b00 ? 2'b01 : 2'b10;
                    end
                    state <= (op == 2'b01 || snp_hit) ? DONE : FETCH;
                end
                FETCH: begin
                    cnt <= cnt + 1'b1;
                    if (bus.l2_ready) begin
                        data  <= bus.l2_rdata;
                        code  <= 2'b10;
                        state <= DONE;
                    end else if (cnt == LAST) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    rr    <= ~owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant_0            = state != IDLE && !owner;
    assign bus.grant_1            = state != IDLE && owner;
    assign bus.bus_operation_in_0 = (state == SNOOP && owner) ? op : 2'b11;
    assign bus.bus_operation_in_1 = (state == SNOOP && !owner) ? op : 2'b11;
    assign bus.bus_address_in_0   = (state == SNOOP && owner) ? addr : '0;
    assign bus.bus_address_in_1   = (state == SNOOP && !owner) ? addr : '0;
    assign bus.bus_data_in_0      = (state == DONE && !owner) ? data : '0;
    assign bus.bus_data_in_1      = (state == DONE && owner) ? data : '0;
    assign bus.cache_hit_in_0     = (state == DONE && !owner) ? code : 2'b00;
    assign bus.cache_hit_in_1     = (state == DONE && owner) ? code : 2'b00;
    assign bus.l2_req             = state == FETCH;
    assign bus.l2_we              = flush_now;
    assign bus.l2_wdata           = flush_now ? snp_wdata : '0;
    // write-back targets the flushed line's tag with the snooped offset; fetch uses the request address
    assign bus.l2_addr            = flush_now ? {snp_tag[23:0], addr[7:0]} : (state == FETCH ? addr : '0);
    assign bus.bus_error          = err;
endmodule

// File: tb/tb_bus_controller.sv
// tb_bus_controller: directed scenario checks of bus_controller arbitration, snoop, fill, flush and timeout.
module tb_bus_controller;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int pass = 0;
    int total = 0;

    bus_controller_if bif();
    bus_controller #(.L2_TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bif));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        #3;
        total++; if (bif.grant_0 !== 1'b0 || bif.grant_1 !== 1'b0) $display("FAIL reset_grant: got %b%b expected 00", bif.grant_0, bif.grant_1); else pass++;
        total++; if (bif.bus_operation_in_0 !== 2'b11 || bif.bus_operation_in_1 !== 2'b11) $display("FAIL reset_op_in: got %b/%b expected 11/11", bif.bus_operation_in_0, bif.bus_operation_in_1); else pass++;
        total++; if ({bif.l2_req, bif.l2_we, bif.bus_error} !== 3'b000 || bif.bus_data_in_0 !== 32'h0 || bif.cache_hit_in_1 !== 2'b00) $display("FAIL reset_outs: got req/we/err %b%b%b data0 %h code1 %b expected 000 0 00", bif.l2_req, bif.l2_we, bif.bus_error, bif.bus_data_in_0, bif.cache_hit_in_1); else pass++;
        step();
        reset = 1'b0;
    endtask

    task automatic test_rd_hit();
        step(); bif.req_core_0 = 1'b1; bif.bus_operation_out_0 = 2'b00; bif.bus_address_out_0 = 32'h100; #3;
        total++; if (bif.grant_0 !== 1'b0) $display("FAIL hit_idle_grant: got %b expected 0", bif.grant_0); else pass++;
        step(); bif.req_core_0 = 1'b0; #3;
        total++; if (bif.grant_0 !== 1'b1 || bif.grant_1 !== 1'b0) $display("FAIL hit_grant: got %b%b expected 10", bif.grant_0, bif.grant_1); else pass++;
        step(); bif.cache_hit_out_1 = 1'b1; bif.bus_data_out_1 = 32'hDEAD_BEEF; #3;
        total++; if (bif.bus_operation_in_1 !== 2'b00 || bif.bus_address_in_1 !== 32'h100 || bif.bus_operation_in_0 !== 2'b11) $display("FAIL hit_snoop: got op1 %b addr1 %h op0 %b expected 00 100 11", bif.bus_operation_in_1, bif.bus_address_in_1, bif.bus_operation_in_0); else pass++;
        total++; if (bif.l2_req !== 1'b0) $display("FAIL hit_no_l2req_snoop: got %b expected 0", bif.l2_req); else pass++;
        step(); bif.cache_hit_out_1 = 1'b0; bif.bus_data_out_1 = 32'h0; #3;
        total++; if (bif.bus_data_in_0 !== 32'hDEAD_BEEF || bif.cache_hit_in_0 !== 2'b01) $display("FAIL hit_done: got %h/%b expected deadbeef/01", bif.bus_data_in_0, bif.cache_hit_in_0); else pass++;
        total++; if (bif.l2_req !== 1'b0 || bif.bus_data_in_1 !== 32'h0) $display("FAIL hit_done_side: got l2_req %b data1 %h expected 0 0", bif.l2_req, bif.bus_data_in_1); else pass++;
        step(); #3;
        total++; if (bif.bus_data_in_0 !== 32'h0 || bif.grant_0 !== 1'b0) $display("FAIL hit_idle_after: got %h grant %b expected 0 0", bif.bus_data_in_0, bif.grant_0); else pass++;
    endtask

    task automatic test_rd_miss();
        step(); bif.req_core_1 = 1'b1; bif.bus_operation_out_1 = 2'b00; bif.bus_address_out_1 = 32'h204;
        step(); bif.req_core_1 = 1'b0;
        step(); #3;
        total++; if (bif.bus_operation_in_0 !== 2'b00 || bif.bus_address_in_0 !== 32'h204) $display("FAIL miss_snoop: got %b %h expected 00 204", bif.bus_operation_in_0, bif.bus_address_in_0); else pass++;
        step(); #3;
        total++; if (bif.l2_req !== 1'b1 || bif.l2_addr !== 32'h204 || bif.l2_we !== 1'b0) $display("FAIL miss_fetch: got req %b addr %h we %b expected 1 204 0", bif.l2_req, bif.l2_addr, bif.l2_we); else pass++;
        step();
        step();
        step(); bif.l2_ready = 1'b1; bif.l2_rdata = 32'h1234_5678;
        step(); bif.l2_ready = 1'b0; bif.l2_rdata = 32'h0; #3;
        total++; if (bif.bus_data_in_1 !== 32'h1234_5678 || bif.cache_hit_in_1 !== 2'b10 || bif.l2_req !== 1'b0) $display("FAIL miss_done: got %h/%b req %b expected 12345678/10 0", bif.bus_data_in_1, bif.cache_hit_in_1, bif.l2_req); else pass++;
        step();
    endtask

    task automatic test_arbitration();
        step(); reset = 1'b1;
        step(); reset = 1'b0; bif.req_core_0 = 1'b1; bif.req_core_1 = 1'b1; bif.bus_operation_out_0 = 2'b11; bif.bus_operation_out_1 = 2'b11;
        step(); #3;
        total++; if (bif.grant_0 !== 1'b1 || bif.grant_1 !== 1'b0) $display("FAIL arb_first: got %b%b expected 10", bif.grant_0, bif.grant_1); else pass++;
        step(); #3;
        total++; if (bif.bus_operation_in_1 !== 2'b11 || bif.grant_0 !== 1'b1) $display("FAIL arb_nonop_done: got op1 %b grant0 %b expected 11 1", bif.bus_operation_in_1, bif.grant_0); else pass++;
        step();
        step(); #3;
        total++; if (bif.grant_1 !== 1'b1 || bif.grant_0 !== 1'b0) $display("FAIL arb_second: got %b%b expected 01", bif.grant_0, bif.grant_1); else pass++;
        bif.req_core_1 = 1'b0;
        step(); #3;
        total++; if (bif.grant_0 !== 1'b0) $display("FAIL arb_wait: got %b expected 0", bif.grant_0); else pass++;
        step();
        step(); #3;
        total++; if (bif.grant_0 !== 1'b1 || bif.grant_1 !== 1'b0) $display("FAIL arb_third: got %b%b expected 10", bif.grant_0, bif.grant_1); else pass++;
        bif.req_core_0 = 1'b0;
        step();
        step();
    endtask

    task automatic test_flush();
        step(); bif.req_core_0 = 1'b1; bif.bus_operation_out_0 = 2'b10; bif.bus_address_out_0 = 32'h3C0;
        step(); bif.req_core_0 = 1'b0;
        step(); bif.cache_hit_out_1 = 1'b1; bif.flush_out_1 = 1'b1; bif.bus_data_out_1 = 32'hA5A5_A5A5; bif.data_to_L2_1 = 32'hA5A5_A5A5; bif.tag_to_L2_1 = 25'h0AB_CDEF; #3;
        total++; if (bif.l2_we !== 1'b1 || bif.l2_wdata !== 32'hA5A5_A5A5 || bif.l2_req !== 1'b0) $display("FAIL flush_we: got we %b wdata %h req %b expected 1 a5a5a5a5 0", bif.l2_we, bif.l2_wdata, bif.l2_req); else pass++;
        total++; if (bif.l2_addr !== 32'hABCD_EFC0 || bif.bus_operation_in_1 !== 2'b10) $display("FAIL flush_addr: got %h op1 %b expected abcdefc0 10", bif.l2_addr, bif.bus_operation_in_1); else pass++;
        step(); bif.cache_hit_out_1 = 1'b0; bif.flush_out_1 = 1'b0; bif.bus_data_out_1 = 32'h0; bif.data_to_L2_1 = 32'h0; bif.tag_to_L2_1 = 25'h0; #3;
        total++; if (bif.cache_hit_in_0 !== 2'b10 || bif.bus_data_in_0 !== 32'hA5A5_A5A5 || bif.l2_we !== 1'b0) $display("FAIL flush_done: got %b %h we %b expected 10 a5a5a5a5 0", bif.cache_hit_in_0, bif.bus_data_in_0, bif.l2_we); else pass++;
        step();
    endtask

    task automatic test_upgrade();
        step(); bif.req_core_0 = 1'b1; bif.bus_operation_out_0 = 2'b01; bif.bus_address_out_0 = 32'h500;
        step(); bif.req_core_0 = 1'b0;
        step(); bif.cache_hit_out_1 = 1'b1; #3;
        total++; if (bif.bus_operation_in_1 !== 2'b01) $display("FAIL upgr_snoop: got %b expected 01", bif.bus_operation_in_1); else pass++;
        step(); bif.cache_hit_out_1 = 1'b0; #3;
        total++; if (bif.l2_req !== 1'b0 || bif.cache_hit_in_0 !== 2'b00 || bif.grant_0 !== 1'b1) $display("FAIL upgr_done: got req %b code %b grant %b expected 0 00 1", bif.l2_req, bif.cache_hit_in_0, bif.grant_0); else pass++;
        step();
    endtask

    task automatic test_timeout();
        logic bad;
        bad = 1'b0;
        step(); bif.req_core_0 = 1'b1; bif.bus_operation_out_0 = 2'b00; bif.bus_address_out_0 = 32'h40;
        step(); bif.req_core_0 = 1'b0;
        step(); bif.l2_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < TO; i++) begin
            step(); #3;
            if (bif.bus_error !== 1'b0 || bif.l2_req !== 1'b1) bad = 1'b1;
        end
        total++; if (bad !== 1'b0) $display("FAIL timeout_wait: got early error or dropped l2_req expected clean %0d-cycle FETCH", TO); else pass++;
        step(); #3;
        total++; if (bif.bus_error !== 1'b1 || bif.cache_hit_in_0 !== 2'b00 || bif.bus_data_in_0 !== 32'h0) $display("FAIL timeout_err: got err %b code %b data %h expected 1 00 0", bif.bus_error, bif.cache_hit_in_0, bif.bus_data_in_0); else pass++;
        step(); bif.l2_rdata = 32'h0; #3;
        total++; if (bif.bus_error !== 1'b0 || bif.grant_0 !== 1'b0 || bif.l2_req !== 1'b0) $display("FAIL timeout_idle: got err %b grant %b req %b expected 0 0 0", bif.bus_error, bif.grant_0, bif.l2_req); else pass++;
    endtask

    task automatic test_reset_mid();
        step(); bif.req_core_1 = 1'b1; bif.bus_operation_out_1 = 2'b10; bif.bus_address_out_1 = 32'h80;
        step(); bif.req_core_1 = 1'b0;
        step();
        step(); #3;
        total++; if (bif.l2_req !== 1'b1 || bif.grant_1 !== 1'b1) $display("FAIL rstmid_pre: got req %b grant1 %b expected 1 1", bif.l2_req, bif.grant_1); else pass++;
        step(); reset = 1'b1;
        step(); reset = 1'b0; #3;
        total++; if (bif.l2_req !== 1'b0 || bif.grant_0 !== 1'b0 || bif.grant_1 !== 1'b0 || bif.bus_operation_in_0 !== 2'b11) $display("FAIL rstmid_post: got req %b grants %b%b op0 %b expected 0 00 11", bif.l2_req, bif.grant_0, bif.grant_1, bif.bus_operation_in_0); else pass++;
    endtask

    initial begin
        bif.req_core_0 = 1'b0; bif.req_core_1 = 1'b0;
        bif.bus_operation_out_0 = 2'b11; bif.bus_operation_out_1 = 2'b11;
        bif.bus_address_out_0 = 32'h0; bif.bus_address_out_1 = 32'h0;
        bif.cache_hit_out_0 = 1'b0; bif.cache_hit_out_1 = 1'b0;
        bif.flush_out_0 = 1'b0; bif.flush_out_1 = 1'b0;
        bif.bus_data_out_0 = 32'h0; bif.bus_data_out_1 = 32'h0;
        bif.data_to_L2_0 = 32'h0; bif.data_to_L2_1 = 32'h0;
        bif.tag_to_L2_0 = 25'h0; bif.tag_to_L2_1 = 25'h0;
        bif.l2_rdata = 32'h0; bif.l2_ready = 1'b0;
        test_reset();
        test_rd_hit();
        test_rd_miss();
        test_arbitration();
        test_flush();
        test_upgrade();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
